video_timing_gen: RTL and testbench

//   Generates raster timing for the APF scaler video port (default 640x480@60, 25 MHz clock).

---
 rtl/video_timing_gen_if.sv | 26 ++
 rtl/video_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Pixel fetch bus between the raster timing generator and its pixel source.
//   pix_req  : fetch request, asserted for every visible pixel
//   pix_x    : fetch column, valid with pix_req
//   pix_y    : fetch row, valid with pix_req
//   pix_rgb  : pixel data returned by the source a fixed latency after the request
// master = timing generator, slave = pixel source (framebuffer / cache).
interface video_timing_gen_if;
   logic        pix_req;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [23:0] pix_rgb;

   modport master (
      output pix_req,
      output pix_x,
      output pix_y,
      input  pix_rgb
   );

   modport slave (
      input  pix_req,
      input  pix_x,
      input  pix_y,
      output pix_rgb
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator for the scaler video port.
// Walks a 10-bit horizontal/vertical counter pair over the active, front porch, sync and back
// porch regions, issues a fetch for each visible pixel and presents registered video outputs
// aligned to the returned pixel data (request -> output latency PIX_LAT+1 cycles).
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   i_en          timing enable; low parks the raster at the origin and blanks all outputs
//   pix           pixel fetch bus (master side): req/x/y out, rgb in
//   o_video_rgb   pixel colour, zero outside data enable
//   o_video_de    data enable
//   o_video_hs    one-cycle hsync pulse at the start of the horizontal sync region
//   o_video_vs    one-cycle vsync pulse at the start of the vertical sync region
//   o_video_skip  always 0
//   o_vblank_irq  one-cycle pulse at the start of vertical blank
//   o_frame_cnt   completed-frame counter, steps with o_vblank_irq
module video_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIX_LAT  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   video_timing_gen_if.master  pix,
   output logic [23:0]         o_video_rgb,
   output logic                o_video_de,
   output logic                o_video_hs,
   output logic                o_video_vs,
   output logic                o_video_skip,
   output logic                o_vblank_irq,
   output logic [15:0]         o_frame_cnt
);

   // Totals must fit the 10-bit counters (<= 1024).
   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] HLast      = 10'(HTotal - 1);
   localparam logic [9:0] VLast      = 10'(VTotal - 1);
   localparam logic [9:0] HActive    = 10'(H_ACTIVE);
   localparam logic [9:0] VActive    = 10'(V_ACTIVE);
   localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;

   // Each delay stage carries {de, hs, vs, vb}.
   logic [PIX_LAT-1:0][3:0] pipe_q, pipe_d;
   logic [3:0]              pipe_tail;

   logic        stage_de, stage_hs, stage_vs, stage_vb;

   logic [23:0] rgb_q, rgb_d;
   logic        de_q, de_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        irq_q, irq_d;
   logic        skip_q;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Raster counters
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (!i_en) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (hcnt_q == HLast) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
      end else begin
         hcnt_d = hcnt_q + 10'd1;
      end
   end

   // Counter stage: decoded directly from the counter registers
   always_comb begin
      stage_de = i_en && (hcnt_q < HActive) && (vcnt_q < VActive);
      stage_hs = i_en && (hcnt_q == HSyncStart);
      stage_vs = i_en && (vcnt_q == VSyncStart) && (hcnt_q == 10'd0);
      stage_vb = i_en && (vcnt_q == VActive) && (hcnt_q == 10'd0);
   end

   assign pix.pix_req = stage_de;
   assign pix.pix_x   = hcnt_q;
   assign pix.pix_y   = vcnt_q;

   // Delay line matching the pixel source latency; flushed whenever the raster is disabled so
   // no partial sync or interrupt escapes after a restart.
   always_comb begin
      pipe_d = '0;
      if (i_en) begin
         pipe_d[0] = {stage_de, stage_hs, stage_vs, stage_vb};
         for (int i = 1; i < int'(PIX_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end
   end

   assign pipe_tail = pipe_q[PIX_LAT-1];

   // Output stage: pixel data is sampled in the same cycle its delayed de reaches the tail.
   always_comb begin
      rgb_d = '0;
      de_d  = 1'b0;
      hs_d  = 1'b0;
      vs_d  = 1'b0;
      irq_d = 1'b0;
      if (i_en) begin
         de_d  = pipe_tail[3];
         hs_d  = pipe_tail[2];
         vs_d  = pipe_tail[1];
         irq_d = pipe_tail[0];
         rgb_d = pipe_tail[3] ? pix.pix_rgb : 24'h0;
      end
      // Frame count survives an enable drop; only reset clears it.
      frame_cnt_d = frame_cnt_q + {15'd0, irq_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         pipe_q      <= '0;
         rgb_q       <= '0;
         de_q        <= 1'b0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         irq_q       <= 1'b0;
         skip_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         pipe_q      <= pipe_d;
         rgb_q       <= rgb_d;
         de_q        <= de_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         irq_q       <= irq_d;
         skip_q      <= 1'b0;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign o_video_rgb  = rgb_q;
   assign o_video_de   = de_q;
   assign o_video_hs   = hs_q;
   assign o_video_vs   = vs_q;
   assign o_video_skip = skip_q;
   assign o_vblank_irq = irq_q;
   assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-raster instance checked every cycle against a
// frame-position model, plus a default-size instance checked at a few hand-computed points.
module tb_video_timing_gen;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int LAT = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int NCYC = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small-raster DUT
   logic        rst, en;
   logic [23:0] rgb;
   logic        de, hs, vs, skip, irq;
   logic [15:0] fc;
   video_timing_gen_if bus ();

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .PIX_LAT(LAT)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (en),
      .pix          (bus),
      .o_video_rgb  (rgb),
      .o_video_de   (de),
      .o_video_hs   (hs),
      .o_video_vs   (vs),
      .o_video_skip (skip),
      .o_vblank_irq (irq),
      .o_frame_cnt  (fc)
   );

   // Default 640x480 DUT, PIX_LAT=1
   logic        rst2;
   logic        en2 = 1'b1;
   logic [23:0] rgb2;
   logic        de2, hs2, vs2, skip2, irq2;
   logic [15:0] fc2;
   video_timing_gen_if bus2 ();

   video_timing_gen u_dut_dflt (
      .clk          (clk),
      .rst          (rst2),
      .i_en         (en2),
      .pix          (bus2),
      .o_video_rgb  (rgb2),
      .o_video_de   (de2),
      .o_video_hs   (hs2),
      .o_video_vs   (vs2),
      .o_video_skip (skip2),
      .o_vblank_irq (irq2),
      .o_frame_cnt  (fc2)
   );

   int errors = 0;
   int checks = 0;
   int cur = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cur, act, exp);
      end
   endtask

   // Model history, one entry per cycle
   bit          en_h  [NCYC];
   bit          rst_h [NCYC];
   int          pos_h [NCYC];
   logic [23:0] rgb_h [NCYC];
   int          fc_h  [NCYC];

   initial begin
      int          pos, src, h, v, sh, sv, de2_cnt;
      bit          ok, r, e, e_de, e_hs, e_vs, e_vb, e_req;
      logic [23:0] e_rgb, drv;
      logic [23:0] nxt2;

      rst  = 1'b1;
      en   = 1'b1;
      rst2 = 1'b1;
      bus.pix_rgb  = '0;
      bus2.pix_rgb = '0;
      nxt2 = '0;
      de2_cnt = 0;

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cur = c;

         // Linear position within the frame; reset or disable returns to the origin.
         if (c == 0 || rst_h[c-1] || !en_h[c-1]) pos = 0;
         else pos = (pos_h[c-1] + 1) % FT;
         pos_h[c] = pos;

         // Registered outputs reflect the counter stage LAT+1 cycles back, provided the raster
         // ran uninterrupted through every cycle since then.
         ok = (c >= LAT + 1);
         if (ok) begin
            for (int k = c - LAT - 1; k < c; k++) ok = ok && en_h[k] && !rst_h[k];
         end
         e_de = 0; e_hs = 0; e_vs = 0; e_vb = 0; e_rgb = '0;
         if (ok) begin
            src = c - LAT - 1;
            sh = pos_h[src] % HT;
            sv = pos_h[src] / HT;
            e_de = (sh < HA) && (sv < VA);
            e_hs = (sh == HA + HF);
            e_vs = (sv == VA + VF) && (sh == 0);
            e_vb = (sv == VA) && (sh == 0);
            e_rgb = e_de ? rgb_h[c-1] : 24'h0;
         end
         if (c == 0 || rst_h[c-1]) fc_h[c] = 0;
         else fc_h[c] = (fc_h[c-1] + int'(e_vb)) % 65536;

         chk("de",    32'(de),   32'(e_de));
         chk("hs",    32'(hs),   32'(e_hs));
         chk("vs",    32'(vs),   32'(e_vs));
         chk("irq",   32'(irq),  32'(e_vb));
         chk("rgb",   32'(rgb),  32'(e_rgb));
         chk("frame", 32'(fc),   32'(fc_h[c]));
         chk("skip",  32'(skip), 32'd0);

         // Hand-computed points (raster origin at cycle 3)
         case (c)
            15:  chk("lit_hs_before", 32'(hs), 32'd0);
            16:  chk("lit_hs_first", 32'(hs), 32'd1);
            62:  begin
               chk("lit_irq_first", 32'(irq), 32'd1);
               chk("lit_frame_1", 32'(fc), 32'd1);
            end
            76:  chk("lit_vs_first", 32'(vs), 32'd1);
            133: begin
               chk("lit_drop_de", 32'(de), 32'd0);
               chk("lit_drop_rgb", 32'(rgb), 32'd0);
               chk("lit_drop_frame", 32'(fc), 32'd1);
            end
            192: chk("lit_frame_2", 32'(fc), 32'd2);
            206: chk("lit_vs_after_drop", 32'(vs), 32'd1);
            248: begin
               chk("lit_rst_de", 32'(de), 32'd0);
               chk("lit_rst_frame", 32'(fc), 32'd0);
            end
            default: ;
         endcase

         // Stimulus for this cycle
         if (c < 3) begin
            r = 1; e = 1;
         end else if (c == 132) begin
            r = 0; e = 0;
         end else if (c == 247) begin
            r = 1; e = 1;
         end else if (c >= 260) begin
            e = ($urandom_range(49) != 0);
            r = ($urandom_range(499) == 0);
         end else begin
            r = 0; e = 1;
         end
         drv = 24'($urandom);
         en_h[c]  = e;
         rst_h[c] = r;
         rgb_h[c] = drv;
         rst = r;
         en  = e;
         bus.pix_rgb = drv;

         rst2 = (c < 3);
         bus2.pix_rgb = nxt2;
         #1;

         // Combinational fetch request
         h = pos % HT;
         v = pos / HT;
         e_req = e && (h < HA) && (v < VA);
         chk("req", 32'(bus.pix_req), 32'(e_req));
         if (e_req) begin
            chk("req_x", 32'(bus.pix_x), 32'(h));
            chk("req_y", 32'(bus.pix_y), 32'(v));
         end
         if (c == 133 || c == 248) begin
            chk("lit_restart_req", 32'(bus.pix_req), 32'd1);
            chk("lit_restart_xy", {12'h0, bus.pix_x, bus.pix_y}, 32'd0);
         end

         // Default-size instance: source returns {0, y, x} one cycle after the request
         nxt2 = {8'h0, bus2.pix_y[7:0], bus2.pix_x[7:0]};
         if (c >= 5 && c <= 804 && de2) de2_cnt++;
         case (c)
            5: begin
               chk("dflt_first_de", 32'(de2), 32'd1);
               chk("dflt_first_rgb", 32'(rgb2), 32'h0);
            end
            10:  chk("dflt_rgb_x5", 32'(rgb2), 32'h000005);
            650: begin
               chk("dflt_blank_de", 32'(de2), 32'd0);
               chk("dflt_blank_rgb", 32'(rgb2), 32'h0);
            end
            660: chk("dflt_hs_before", 32'(hs2), 32'd0);
            661: chk("dflt_hs", 32'(hs2), 32'd1);
            804: chk("dflt_de_per_line", 32'(de2_cnt), 32'd640);
            805: chk("dflt_line1_rgb", 32'(rgb2), 32'h000100);
            default: ;
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
